ddr3_return_unpacker: RTL and testbench
=======================================

Name: ddr3_return_unpacker

Overview:
- Downstream consumer of the controller's return FIFO. Each entry is 42 bits: {addr[25:0], data[15:0]}.
- Drains BL consecutive entries and assembles them into one burst-wide line with its base address.
- Presents the line to the host with a valid/ready handshake.
- Replaces the raw per-beat dout/raddr/validout path with a burst-aligned line interface.

Parameters:
- BL, 8, beats per burst line; power of two, 2..16.
- DW, 16, data bits per beat.
- AW, 26, address bits per beat.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- ret_data  input  AW+DW  return FIFO read data {addr, data}; valid the cycle after ret_get.
- ret_fillcount  input  6  return FIFO occupancy.
- ret_get  output  1  return FIFO read enable.
- line_valid  output  1  assembled line available.
- line_ready  input  1  host accepts line.
- line_addr  output  AW  address of beat 0.
- line_data  output  BL*DW  beat k at bits [DW*k +: DW]; beat 0 is least significant.
- line_err  output  1  address-continuity error for the presented line.
- lines_done  output  16  count of accepted lines; wraps at 2^16.

Behaviour:
- Reset (synchronous, active-high, clock clk) values:
  - ret_get=0, line_valid=0, line_addr=0, line_data=0, line_err=0, lines_done=0.
  - State=COLLECT, issued=0, captured=0, get_q=0.
  - Reset mid-line discards any partial line. The FIFO is reset by its own owner.
- States: COLLECT and PRESENT.
- COLLECT, fetch rule:
  - ret_get=1 iff issued<BL and (ret_fillcount>=2, or ret_fillcount==1 and get_q==0).
  - This prevents over-read against the FIFO's registered fill count.
  - issued increments on each ret_get.
  - get_q is ret_get registered.
- COLLECT, capture rule (cycle after each get, i.e. get_q=1):
  - ret_data[DW-1:0] is written to beat slot captured.
  - If captured==0, line_addr <= ret_data[AW+DW-1:DW].
  - captured increments.
- COLLECT to PRESENT:
  - Taken on the capture cycle where captured==BL-1.
  - line_valid=1 on the following cycle; issued and captured clear.
  - ret_get is held 0 throughout PRESENT.
- PRESENT:
  - line_valid, line_addr, line_data and line_err are held stable until line_ready=1 is sampled.
  - On accept: line_valid=0 and state=COLLECT next cycle, and lines_done increments.
  - ret_get may assert in that same next cycle.
- Latency: with the FIFO holding at least BL+1 entries, line_valid rises BL+1 cycles after entry to COLLECT (one get per cycle).
  - With ret_fillcount==1 steady, gets alternate and the minimum is 2*BL cycles.
- line_ready while line_valid=0 is ignored.
- line_data is not cleared between lines; slots are overwritten.
- An empty FIFO mid-line stalls collection indefinitely, with no timeout.

Optional Feature:
- Macro: RETURN_ADDR_CHECK_EN.
- Defined:
  - For capture k>=1, expected address is line_addr with low log2(BL) bits replaced by (line_addr[log2(BL)-1:0]+k) mod BL, i.e. sequential wrap within the burst.
  - Any mismatch sets a sticky error flag, which is presented as line_err with the line.
  - The flag clears on accept or reset.
- Undefined: line_err tied to 0 and no comparator logic is built.

Test Plan:
- Preload 8 entries, addr 0x0000100..0x0000107, data 0xA000..0xA007, line_ready=1 → line_valid rises 9 cycles after COLLECT entry; line_addr=0x0000100; line_data[15:0]=0xA000 and [127:112]=0xA007; lines_done=1.
- Trickle entries one every 3 cycles, with ret_fillcount never above 1 → no get issued with fillcount 0; exactly 8 gets; same line as above.
- Line presented, line_ready=0 for 20 cycles with 8 more entries queued → outputs stable, ret_get=0 throughout; on line_ready=1, the next line arrives with addr 0x0000108.
- Base addr 0x0000105 with wrap sequence 5,6,7,0,1,2,3,4 → line_err=0. Repeat with beat 3 addr 0x0000109 → line_err=1 under RETURN_ADDR_CHECK_EN, 0 without; lines_done still increments.
- Assert reset after 4 captures → all outputs 0 next cycle; the following 8 entries form a clean line starting from beat 0.
- Accept 65536 lines (counter forced near max) → lines_done wraps 0xFFFF→0x0000.

Source files
------------

// File: rtl/ddr3_return_unpacker.sv
// rtl/ddr3_return_unpacker.sv - drains BL return-FIFO beats into one burst-wide line with its base address.
// Optional macro RETURN_ADDR_CHECK_EN enables the in-burst address-continuity check driving line_err.
module ddr3_return_unpacker #(
    parameter int BL = 8,
    parameter int DW = 16,
    parameter int AW = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW+DW-1:0]     ret_data,
    input  logic [5:0]           ret_fillcount,
    output logic                 ret_get,
    output logic                 line_valid,
    input  logic                 line_ready,
    output logic [AW-1:0]        line_addr,
    output logic [BL*DW-1:0]     line_data,
    output logic                 line_err,
    output logic [15:0]          lines_done
);

    localparam int LB = $clog2(BL);
    localparam int CW = LB + 1;

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      issued_q, issued_d;
    logic [LB-1:0]      captured_q, captured_d;
    logic               get_q, get_d;
    logic [AW-1:0]      line_addr_q, line_addr_d;
    logic [BL*DW-1:0]   line_data_q, line_data_d;
    logic [15:0]        lines_done_q, lines_done_d;
    logic               fetch_ok;
    logic               get_en;
    logic               capture;
    logic               accept;

    // The FIFO fill count lags our own read by a cycle, so a count of 1 right
    // after a get may already be spoken for.
    always_comb begin
        fetch_ok = (ret_fillcount >= 6'd2) || ((ret_fillcount == 6'd1) && !get_q);
        get_en   = !reset && (state_q == COLLECT) && (issued_q < CW'(BL)) && fetch_ok;
        capture  = (state_q == COLLECT) && get_q;
        accept   = (state_q == PRESENT) && line_ready;
    end

    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        captured_d   = captured_q;
        get_d        = get_en;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        lines_done_d = lines_done_q;

        if (get_en) begin
            issued_d = issued_q + CW'(1);
        end

        if (capture) begin
            line_data_d[int'(captured_q)*DW +: DW] = ret_data[DW-1:0];
            if (captured_q == '0) begin
                line_addr_d = ret_data[AW+DW-1:DW];
            end
            if (captured_q == LB'(BL-1)) begin
                state_d    = PRESENT;
                issued_d   = '0;
                captured_d = '0;
            end else begin
                captured_d = captured_q + LB'(1);
            end
        end

        if (accept) begin
            state_d      = COLLECT;
            lines_done_d = lines_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            issued_q     <= '0;
            captured_q   <= '0;
            get_q        <= 1'b0;
            line_addr_q  <= '0;
            line_data_q  <= '0;
            lines_done_q <= '0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            captured_q   <= captured_d;
            get_q        <= get_d;
            line_addr_q  <= line_addr_d;
            line_data_q  <= line_data_d;
            lines_done_q <= lines_done_d;
        end
    end

`ifdef RETURN_ADDR_CHECK_EN
    logic          err_q, err_d;
    logic [AW-1:0] exp_addr;

    // Beat k must carry the base address with its low bits advanced by k, wrapping inside the burst.
    always_comb begin
        exp_addr          = line_addr_q;
        exp_addr[LB-1:0]  = line_addr_q[LB-1:0] + captured_q;
        err_d             = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (capture && (captured_q != '0) && (ret_data[AW+DW-1:DW] != exp_addr)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign line_err = err_q;
`else
    assign line_err = 1'b0;
`endif

    assign ret_get    = get_en;
    assign line_valid = (state_q == PRESENT);
    assign line_addr  = line_addr_q;
    assign line_data  = line_data_q;
    assign lines_done = lines_done_q;

endmodule

// File: tb/tb_ddr3_return_unpacker.sv
// tb/tb_ddr3_return_unpacker.sv - scoreboard bench for ddr3_return_unpacker with a lagging-count return FIFO model.
module tb_ddr3_return_unpacker;

    localparam int BL = 8;
    localparam int DW = 16;
    localparam int AW = 26;
`ifdef RETURN_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [AW+DW-1:0]  ret_data;
    logic [5:0]        ret_fillcount;
    logic              ret_get;
    logic              line_valid;
    logic              line_ready;
    logic [AW-1:0]     line_addr;
    logic [BL*DW-1:0]  line_data;
    logic              line_err;
    logic [15:0]       lines_done;

    always #5 clk = ~clk;

    ddr3_return_unpacker #(.BL(BL), .DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ret_data      (ret_data),
        .ret_fillcount (ret_fillcount),
        .ret_get       (ret_get),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .line_addr     (line_addr),
        .line_data     (line_data),
        .line_err      (line_err),
        .lines_done    (lines_done)
    );

    typedef struct {
        logic [AW-1:0]    addr;
        logic [BL*DW-1:0] data;
        logic             err;
    } line_t;

    line_t             sb[$];
    logic [AW+DW-1:0]  fifo[$];
    int                total = 0;
    int                bad = 0;
    int                get_cnt = 0;
    logic [15:0]       exp_done = 16'd0;

    task automatic chk(input string name, input logic [BL*DW-1:0] act, input logic [BL*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Return FIFO: data appears the cycle after a get; the reported count lags the pop by one cycle.
    initial begin
        logic g;
        ret_data      = '0;
        ret_fillcount = '0;
        forever begin
            @(posedge clk);
            g = ret_get;
            #1;
            ret_fillcount = (fifo.size() > 63) ? 6'd63 : 6'(fifo.size());
            if (g && fifo.size() > 0) ret_data = fifo.pop_front();
        end
    end

    // Monitor: fetch safety, PRESENT stability, and scoreboard compare on each accepted line.
    initial begin
        line_t            e;
        bit               held = 1'b0;
        logic [AW-1:0]    h_addr;
        logic [BL*DW-1:0] h_data;
        logic             h_err;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_done = 16'd0;
                held     = 1'b0;
            end else begin
                if (ret_get) begin
                    get_cnt++;
                    chk("get_with_fc0", ret_fillcount == 6'd0, 1'b0);
                    chk("get_underflow", fifo.size() == 0, 1'b0);
                end
                if (line_valid) begin
                    chk("get_in_present", ret_get, 1'b0);
                    if (held) begin
                        chk("hold_addr", line_addr, h_addr);
                        chk("hold_data", line_data, h_data);
                        chk("hold_err", line_err, h_err);
                    end else begin
                        h_addr = line_addr;
                        h_data = line_data;
                        h_err  = line_err;
                        held   = 1'b1;
                    end
                    if (line_ready) begin
                        total++;
                        if (sb.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_line actual=%0h required=none", line_addr);
                        end else begin
                            e = sb.pop_front();
                            chk("line_addr", line_addr, e.addr);
                            chk("line_data", line_data, e.data);
                            chk("line_err", line_err, e.err);
                        end
                        chk("lines_done", lines_done, exp_done);
                        exp_done = exp_done + 16'd1;
                        held     = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [AW-1:0] base, input logic [15:0] dbase,
                             input int bad_beat, input logic [AW-1:0] bad_addr, input int gap);
        line_t         e;
        logic [AW-1:0] a;
        logic [2:0]    lo;
        e.addr = base;
        e.data = '0;
        e.err  = CHK && (bad_beat >= 0);
        sb.push_back(e);
        for (int k = 0; k < BL; k++) begin
            lo = base[2:0] + 3'(k);
            a  = {base[AW-1:3], lo};
            if (k == bad_beat) a = bad_addr;
            sb[sb.size()-1].data[DW*k +: DW] = dbase + 16'(k);
            fifo.push_back({a, dbase + 16'(k)});
            if (gap > 0) tick(gap);
        end
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((sb.size() != 0 || fifo.size() != 0) && n < max) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n >= max, 1'b0);
        tick(3);
    endtask

    initial begin
        int n;
        int lat;
        int g0;
        reset      = 1'b1;
        line_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ret_get", ret_get, 1'b0);
        chk("rst_line_valid", line_valid, 1'b0);
        chk("rst_line_addr", line_addr, '0);
        chk("rst_line_data", line_data, '0);
        chk("rst_line_err", line_err, 1'b0);
        chk("rst_lines_done", lines_done, 16'h0000);

        // Preloaded burst: 0x100..0x107 / 0xA000..0xA007, line_valid 9 cycles after first get.
        line_ready = 1'b1;
        push_line(26'h0000100, 16'hA000, -1, '0, 0);
        n = 0;
        while (!ret_get && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_get_timeout", n >= 20, 1'b0);
        lat = 0;
        while (!line_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 9);
        chk("beat0_data", line_data[15:0], 16'hA000);
        chk("beat7_data", line_data[127:112], 16'hA007);
        chk("line1_addr", line_addr, 26'h0000100);
        wait_drain(200);
        chk("lines_done_1", lines_done, 16'h0001);

        // Trickle: one entry every 3 cycles, exactly 8 gets.
        g0 = get_cnt;
        push_line(26'h0000100, 16'hA000, -1, '0, 3);
        wait_drain(200);
        chk("trickle_gets", get_cnt - g0, 8);

        // Backpressure: hold the line 20 cycles with the next burst already queued.
        line_ready = 1'b0;
        push_line(26'h0000100, 16'hB000, -1, '0, 0);
        push_line(26'h0000108, 16'hB100, -1, '0, 0);
        n = 0;
        while (!line_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_timeout", n >= 40, 1'b0);
        tick(20);
        line_ready = 1'b1;
        wait_drain(200);

        // In-burst wrap 5,6,7,0..4, then the same with beat 3 at a wrong address.
        push_line(26'h0000105, 16'hC000, -1, '0, 0);
        push_line(26'h0000105, 16'hC100, 3, 26'h0000109, 0);
        wait_drain(200);

        // Reset after 4 captures, then a clean line.
        for (int k = 0; k < 4; k++) fifo.push_back({26'h0000300 + 26'(k), 16'hD000 + 16'(k)});
        tick(12);
        reset = 1'b1;
        tick(1);
        @(negedge clk);
        chk("mid_rst_ret_get", ret_get, 1'b0);
        chk("mid_rst_valid", line_valid, 1'b0);
        chk("mid_rst_addr", line_addr, '0);
        chk("mid_rst_data", line_data, '0);
        chk("mid_rst_err", line_err, 1'b0);
        chk("mid_rst_done", lines_done, 16'h0000);
        #2;
        reset = 1'b0;
        push_line(26'h0000200, 16'hE000, -1, '0, 0);
        wait_drain(200);
        chk("post_rst_done", lines_done, 16'h0001);

        // Counter wrap from 0xFFFE through 0xFFFF to 0x0000.
        @(negedge clk);
        force dut.lines_done_q = 16'hFFFE;
        #1;
        release dut.lines_done_q;
        exp_done = 16'hFFFE;
        push_line(26'h0000400, 16'hF000, -1, '0, 0);
        push_line(26'h0000408, 16'hF100, -1, '0, 0);
        wait_drain(200);
        chk("done_wrap", lines_done, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
